// File: rtl/huff_phase_ctrl.sv
// Phase sequencer for the Huffman datapath: collects the symbol stream into the
// count engine, then sequences sort and tree engines via go/done handshakes.
module huff_phase_ctrl #(
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 6,
  parameter int TMO_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SYM_W-1:0]  indata,
  input  logic [ADDR_W-1:0] addr,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic [SYM_W-1:0]  cnt_data,
  output logic              sort_go,
  input  logic              sort_done,
  output logic              tree_go,
  input  logic              tree_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_SORT, S_BUILD, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

  state_t             state_q, state_d;
  logic               cnt_clr_q, cnt_clr_d;
  logic               cnt_en_q, cnt_en_d;
  logic [SYM_W-1:0]   cnt_data_q, cnt_data_d;
  logic               sort_go_q, sort_go_d;
  logic               tree_go_q, tree_go_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   timer_q, timer_d;
  logic [TMO_W-1:0]   timer_inc;

  always_comb begin
    state_d      = state_q;
    cnt_clr_d    = 1'b0;
    cnt_en_d     = 1'b0;
    cnt_data_d   = cnt_data_q;
    sort_go_d    = 1'b0;
    tree_go_d    = 1'b0;
    rd_addr_d    = rd_addr_q;
    sample_cnt_d = sample_cnt_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    timer_d      = timer_q;
    timer_inc    = timer_q + TMO_W'(1);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_COLLECT;
          cnt_clr_d    = 1'b1;
          cnt_en_d     = 1'b1;
          cnt_data_d   = indata;
          sample_cnt_d = CNT_W'(1);
          ovf_d        = 1'b0;
          err_d        = 1'b0;
        end
      end
      S_COLLECT: begin
        if (start) begin
          // Saturated counter drops further samples rather than wrapping.
          if (sample_cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_en_d     = 1'b1;
            cnt_data_d   = indata;
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
        end else begin
          sort_go_d = 1'b1;
          timer_d   = '0;
          state_d   = S_SORT;
        end
      end
      S_SORT: begin
        if (sort_done) begin
          tree_go_d = 1'b1;
          timer_d   = '0;
          state_d   = S_BUILD;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TMO_MAX) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_BUILD: begin
        if (tree_done) begin
          state_d = S_DONE;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TMO_MAX) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs reflect the state being entered so they register with it.
    done_d  = (state_d == S_DONE);
    rd_en_d = (state_d == S_DONE);
    busy_d  = (state_d == S_COLLECT) || (state_d == S_SORT) || (state_d == S_BUILD);
    if (state_d == S_DONE) rd_addr_d = addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_clr_q    <= 1'b0;
      cnt_en_q     <= 1'b0;
      cnt_data_q   <= '0;
      sort_go_q    <= 1'b0;
      tree_go_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      sample_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_clr_q    <= cnt_clr_d;
      cnt_en_q     <= cnt_en_d;
      cnt_data_q   <= cnt_data_d;
      sort_go_q    <= sort_go_d;
      tree_go_q    <= tree_go_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      sample_cnt_q <= sample_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
    end
  end

  assign cnt_clr    = cnt_clr_q;
  assign cnt_en     = cnt_en_q;
  assign cnt_data   = cnt_data_q;
  assign sort_go    = sort_go_q;
  assign tree_go    = tree_go_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign sample_cnt = sample_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign err        = err_q;

endmodule
